// File: rtl/pong_pkg.sv
// pong_pkg: state encoding, default geometry/timing constants and a counter-width helper
// shared by game_core and tick_divider.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_POINT    = 3'd3,
    ST_GAMEOVER = 3'd4
  } state_t;

  localparam int DEF_FIELD_W     = 32;
  localparam int DEF_FIELD_H     = 32;
  localparam int DEF_WIN_SCORE   = 9;
  localparam int DEF_STEP_TICKS  = 20;
  localparam int DEF_POINT_TICKS = 64;

  // A modulus of 1 still needs a one-bit register.
  function automatic int cnt_width(input int modulus);
    return (modulus > 1) ? $clog2(modulus) : 1;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// tick_divider: counts enabled ticks 0..MODULUS-1 and flags the tick on which it wraps.
// Synchronous clear and active-low synchronous reset both return the count to zero.
module tick_divider
  import pong_pkg::*;
#(
  parameter int MODULUS = DEF_STEP_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_wrap
);

  localparam int            CW   = cnt_width(MODULUS);
  localparam logic [CW-1:0] TERM = CW'(MODULUS - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] r_cnt;
  logic          w_term;

  assign w_term = (r_cnt == TERM);
  assign o_wrap = i_en && w_term;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_term ? '0 : r_cnt + ONE;
    end
  end

endmodule

// File: rtl/game_core.sv
// game_core: pong ball/score engine.
// IDLE wait start | SERVE ball loaded, wait tick | PLAY ball stepping | POINT hold out flag | GAMEOVER frozen
module game_core
  import pong_pkg::*;
#(
  parameter int FIELD_W     = DEF_FIELD_W,
  parameter int FIELD_H     = DEF_FIELD_H,
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int STEP_TICKS  = DEF_STEP_TICKS,
  parameter int POINT_TICKS = DEF_POINT_TICKS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       start,
  input  logic [4:0]                 entropy,
  input  logic [FIELD_H-1:0]         lpaddle,
  input  logic [FIELD_H-1:0]         rpaddle,
  output logic [$clog2(FIELD_W)-1:0] x,
  output logic [$clog2(FIELD_H)-1:0] y,
  output logic                       out_left,
  output logic                       out_right,
  output logic [3:0]                 score_p1,
  output logic [3:0]                 score_p2,
  output logic                       game_over,
  output logic                       winner
);

  localparam int XW = $clog2(FIELD_W);
  localparam int YW = $clog2(FIELD_H);

  localparam logic [XW-1:0] X_ONE = XW'(1);
  localparam logic [XW-1:0] X_TWO = XW'(2);
  localparam logic [XW-1:0] X_MID = XW'(FIELD_W / 2);
  localparam logic [XW-1:0] X_R1  = XW'(FIELD_W - 1);
  localparam logic [XW-1:0] X_R2  = XW'(FIELD_W - 2);
  localparam logic [XW-1:0] X_R3  = XW'(FIELD_W - 3);
  localparam logic [YW-1:0] Y_ONE = YW'(1);
  localparam logic [YW-1:0] Y_MID = YW'(FIELD_H / 2);
  localparam logic [YW-1:0] Y_T1  = YW'(FIELD_H - 1);
  localparam logic [YW-1:0] Y_T2  = YW'(FIELD_H - 2);
  localparam logic [3:0]    WIN   = 4'(WIN_SCORE);
  localparam logic [3:0]    S_ONE = 4'd1;

  state_t        r_state;
  state_t        w_state_nxt;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_dx_neg;
  logic          r_dy_neg;
  logic          r_serve_left;
  logic [3:0]    r_score_p1;
  logic [3:0]    r_score_p2;
  logic          r_out_left;
  logic          r_out_right;
  logic          r_game_over;
  logic          r_winner;

  logic          w_step;
  logic          w_point_wrap;
  logic          w_serve_load;
  logic          w_restart;
  logic          w_point_done;
  logic          w_game_won;
  logic [YW-1:0] w_serve_y;

  logic [XW-1:0] w_x_nxt;
  logic [YW-1:0] w_y_nxt;
  logic          w_dx_neg_nxt;
  logic          w_dy_neg_nxt;
  logic          w_miss_l;
  logic          w_miss_r;

  tick_divider #(.MODULUS(STEP_TICKS)) u_step_div (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_serve_load),
    .i_en    (tick && (r_state == ST_PLAY)),
    .o_wrap  (w_step)
  );

  tick_divider #(.MODULUS(POINT_TICKS)) u_point_div (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_step),
    .i_en    (tick && (r_state == ST_POINT)),
    .o_wrap  (w_point_wrap)
  );

  assign w_serve_y  = YW'({1'b0, entropy} % 6'(FIELD_H));
  assign w_game_won = (r_score_p1 == WIN) || (r_score_p2 == WIN);

  // Paddle hit uses the pre-step row; vertical reflection applies in the same step.
  always_comb begin
    w_y_nxt      = r_dy_neg ? (r_y - Y_ONE) : (r_y + Y_ONE);
    w_dy_neg_nxt = r_dy_neg;
    if (r_dy_neg && (r_y == '0)) begin
      w_y_nxt      = Y_ONE;
      w_dy_neg_nxt = 1'b0;
    end else if (!r_dy_neg && (r_y == Y_T1)) begin
      w_y_nxt      = Y_T2;
      w_dy_neg_nxt = 1'b1;
    end

    w_x_nxt      = r_dx_neg ? (r_x - X_ONE) : (r_x + X_ONE);
    w_dx_neg_nxt = r_dx_neg;
    w_miss_l     = 1'b0;
    w_miss_r     = 1'b0;
    if (r_dx_neg && (r_x == X_ONE)) begin
      if (lpaddle[r_y]) begin
        w_x_nxt      = X_TWO;
        w_dx_neg_nxt = 1'b0;
      end else begin
        w_x_nxt  = '0;
        w_miss_l = 1'b1;
      end
    end else if (!r_dx_neg && (r_x == X_R2)) begin
      if (rpaddle[r_y]) begin
        w_x_nxt      = X_R3;
        w_dx_neg_nxt = 1'b1;
      end else begin
        w_x_nxt  = X_R1;
        w_miss_r = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_serve_load = 1'b0;
    w_restart    = 1'b0;
    w_point_done = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt  = ST_SERVE;
          w_serve_load = 1'b1;
        end
      end
      ST_SERVE: begin
        if (tick) w_state_nxt = ST_PLAY;
      end
      ST_PLAY: begin
        if (w_step && (w_miss_l || w_miss_r)) w_state_nxt = ST_POINT;
      end
      ST_POINT: begin
        if (w_point_wrap) begin
          w_point_done = 1'b1;
          if (w_game_won) begin
            w_state_nxt = ST_GAMEOVER;
          end else begin
            w_state_nxt  = ST_SERVE;
            w_serve_load = 1'b1;
          end
        end
      end
      ST_GAMEOVER: begin
        if (start) begin
          w_state_nxt  = ST_SERVE;
          w_serve_load = 1'b1;
          w_restart    = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x          <= X_MID;
      r_y          <= Y_MID;
      r_dx_neg     <= 1'b0;
      r_dy_neg     <= 1'b0;
      r_serve_left <= 1'b0;
      r_score_p1   <= '0;
      r_score_p2   <= '0;
      r_out_left   <= 1'b0;
      r_out_right  <= 1'b0;
      r_game_over  <= 1'b0;
      r_winner     <= 1'b0;
    end else begin
      if (w_serve_load) begin
        r_x      <= X_MID;
        r_y      <= w_serve_y;
        r_dy_neg <= ~entropy[0];
        r_dx_neg <= w_restart ? 1'b0 : r_serve_left;
      end
      if (w_restart) begin
        r_score_p1   <= '0;
        r_score_p2   <= '0;
        r_game_over  <= 1'b0;
        r_winner     <= 1'b0;
        r_serve_left <= 1'b0;
      end
      if (w_step) begin
        r_x      <= w_x_nxt;
        r_y      <= w_y_nxt;
        r_dx_neg <= w_dx_neg_nxt;
        r_dy_neg <= w_dy_neg_nxt;
        if (w_miss_l) begin
          if (r_score_p2 < WIN) r_score_p2 <= r_score_p2 + S_ONE;
          r_out_left   <= 1'b1;
          r_serve_left <= 1'b1;
        end
        if (w_miss_r) begin
          if (r_score_p1 < WIN) r_score_p1 <= r_score_p1 + S_ONE;
          r_out_right  <= 1'b1;
          r_serve_left <= 1'b0;
        end
      end
      if (w_point_done) begin
        r_out_left  <= 1'b0;
        r_out_right <= 1'b0;
        if (w_game_won) begin
          r_game_over <= 1'b1;
          r_winner    <= (r_score_p2 == WIN);
        end
      end
    end
  end

  assign x         = r_x;
  assign y         = r_y;
  assign out_left  = r_out_left;
  assign out_right = r_out_right;
  assign score_p1  = r_score_p1;
  assign score_p2  = r_score_p2;
  assign game_over = r_game_over;
  assign winner    = r_winner;

endmodule
